// File: rtl/dot_product_pkg.sv
// dot_product_pkg: shared types and width helpers for the dot_product engine.
// Optional build macro (used by the sub-module): DOT_PRODUCT_SIGNED_EN.
package dot_product_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Width of the accumulator and the result: a full product plus enough
  // headroom bits to add N products without overflow.
  function automatic int result_width(input int width, input int n);
    return 2 * width + $clog2(n);
  endfunction

  // Width of the element index counter; at least one bit, even when N == 1.
  function automatic int index_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dot_product_mac.sv
// dot_product_mac: registered multiply-accumulate with synchronous clear and
// enable. sum_next is the value the accumulator takes on the next enabled edge.
// DOT_PRODUCT_SIGNED_EN selects two's-complement operands and accumulation;
// without it all arithmetic is unsigned.
module dot_product_mac #(
  parameter int WIDTH = 8,
  parameter int ACC_W = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [ACC_W-1:0] sum_next
);

  logic [ACC_W-1:0] acc;

`ifdef DOT_PRODUCT_SIGNED_EN
  logic signed [2*WIDTH-1:0] product;
  logic signed [ACC_W-1:0]   product_ext;

  // Signed product of the two sign-extended operands, then sign-extended to
  // accumulator width so negative products subtract correctly.
  always_comb begin
    product     = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
    product_ext = ACC_W'(product);
    sum_next    = acc + product_ext;
  end
`else
  logic [2*WIDTH-1:0] product;
  logic [ACC_W-1:0]   product_ext;

  // Unsigned full-width product, zero-extended to accumulator width.
  always_comb begin
    product     = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    product_ext = ACC_W'(product);
    sum_next    = acc + product_ext;
  end
`endif

  // Accumulator register: clear has priority over enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (enable) begin
      acc <= sum_next;
    end
  end

endmodule

// File: rtl/dot_product.sv
// dot_product: sequential dot product of two packed N-element vectors, one
// element pair per clock, valid/ready input and one-cycle output_valid pulse.
// Optional build macro: DOT_PRODUCT_SIGNED_EN (signed elements and result).
module dot_product
  import dot_product_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N     = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              input_valid,
  output logic                              input_ready,
  input  logic [WIDTH*N-1:0]                A_vec,
  input  logic [WIDTH*N-1:0]                B_vec,
  output logic [result_width(WIDTH, N)-1:0] result,
  output logic                              output_valid
);

  localparam int RES_W = result_width(WIDTH, N);
  localparam int IDX_W = index_width(N);

  state_t             state_q;
  state_t             state_d;
  logic [WIDTH*N-1:0] a_q;
  logic [WIDTH*N-1:0] b_q;
  logic [IDX_W-1:0]   idx_q;
  logic [WIDTH-1:0]   a_elem;
  logic [WIDTH-1:0]   b_elem;
  logic [RES_W-1:0]   sum_next;
  logic [RES_W-1:0]   result_q;
  logic               output_valid_q;
  logic               accept;
  logic               mac_enable;
  logic               last_elem;

  // Ready is a decode of the registered state, forced low while in reset.
  assign input_ready  = (state_q == IDLE) && !rst;
  assign result       = result_q;
  assign output_valid = output_valid_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: leave IDLE on accept, return after the last element.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)    state_d = BUSY;
      BUSY:    if (last_elem) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs steering the datapath and the MAC.
  always_comb begin
    accept     = (state_q == IDLE) && input_valid && input_ready;
    mac_enable = (state_q == BUSY);
    last_elem  = (state_q == BUSY) && (idx_q == IDX_W'(N - 1));
  end

  // Element mux selecting the current operand pair from the captured vectors.
  always_comb begin
    a_elem = a_q[idx_q*WIDTH +: WIDTH];
    b_elem = b_q[idx_q*WIDTH +: WIDTH];
  end

  // Operand capture, index counting, and result/pulse registers; the final
  // sum is taken from the MAC's next value so it lands on the last edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q            <= '0;
      b_q            <= '0;
      idx_q          <= '0;
      result_q       <= '0;
      output_valid_q <= 1'b0;
    end else begin
      output_valid_q <= last_elem;
      if (accept) begin
        a_q   <= A_vec;
        b_q   <= B_vec;
        idx_q <= '0;
      end else if (mac_enable && !last_elem) begin
        idx_q <= idx_q + IDX_W'(1);
      end
      if (last_elem) begin
        result_q <= sum_next;
      end
    end
  end

  dot_product_mac #(
    .WIDTH(WIDTH),
    .ACC_W(RES_W)
  ) u_mac (
    .clk     (clk),
    .rst     (rst),
    .clear   (accept),
    .enable  (mac_enable),
    .a       (a_elem),
    .b       (b_elem),
    .sum_next(sum_next)
  );

endmodule

// File: tb/tb_dot_product.sv
// tb_dot_product: directed, table-driven bench for dot_product (default
// unsigned build) plus hand-written back-to-back and reset-abort sequences.
module tb_dot_product;

  localparam int WIDTH = 8;
  localparam int N     = 4;
  localparam int VW    = WIDTH * N;
  localparam int RW    = 2 * WIDTH + $clog2(N);

  logic          clk;
  logic          rst;
  logic          input_valid;
  logic          input_ready;
  logic [VW-1:0] A_vec;
  logic [VW-1:0] B_vec;
  logic [RW-1:0] result;
  logic          output_valid;

  int checkCount;
  int errorCount;

  typedef struct {
    logic [VW-1:0] a;
    logic [VW-1:0] b;
    logic [RW-1:0] expected;
  } vec_t;

  vec_t tbl [6];
  vec_t b2b [3];

  dot_product #(
    .WIDTH(WIDTH),
    .N    (N)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .input_valid (input_valid),
    .input_ready (input_ready),
    .A_vec       (A_vec),
    .B_vec       (B_vec),
    .result      (result),
    .output_valid(output_valid)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case a sequence stalls outside its own bounded waits.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Compare one value and log a failure line when it differs.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Present one vector pair, wait for the accept edge, then watch N+2 edges
  // for the result pulse, its latency, and ready staying low while busy.
  task automatic applyStimulus(input string name, input logic [VW-1:0] a,
                               input logic [VW-1:0] b, input logic [RW-1:0] expected);
    int waitCycles;
    int pulseCount;
    int pulseCycle;
    logic busyOk;
    logic [RW-1:0] captured;
    @(negedge clk);
    A_vec       = a;
    B_vec       = b;
    input_valid = 1'b1;
    waitCycles  = 0;
    while (!input_ready && waitCycles < 20) begin
      @(negedge clk);
      waitCycles++;
    end
    if (!input_ready) begin
      checkOutput({name, "_ready_timeout"}, 32'(input_ready), 32'd1);
      input_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    input_valid = 1'b0;
    A_vec       = VW'($urandom);
    B_vec       = VW'($urandom);
    pulseCount  = 0;
    pulseCycle  = -1;
    busyOk      = 1'b1;
    captured    = '0;
    for (int c = 1; c <= N + 2; c++) begin
      @(posedge clk);
      #1;
      if (c < N && input_ready) busyOk = 1'b0;
      if (output_valid) begin
        pulseCount++;
        if (pulseCycle < 0) begin
          pulseCycle = c;
          captured   = result;
        end
      end
    end
    checkOutput({name, "_pulses"},  32'(pulseCount), 32'd1);
    checkOutput({name, "_latency"}, 32'(pulseCycle), 32'(N));
    checkOutput({name, "_result"},  32'(captured),   32'(expected));
    checkOutput({name, "_busy_ready_low"}, 32'(busyOk), 32'd1);
    checkOutput({name, "_result_held"}, 32'(result), 32'(expected));
  endtask

  initial begin
    logic busyOk;

    checkCount  = 0;
    errorCount  = 0;
    rst         = 1'b1;
    input_valid = 1'b0;
    A_vec       = '0;
    B_vec       = '0;

    // MSB-first element lists: {e3, e2, e1, e0}.
    tbl[0] = '{a: {8'd1, 8'd1, 8'd1, 8'd1},     b: {8'd1, 8'd1, 8'd1, 8'd1},     expected: 18'd4};
    tbl[1] = '{a: {8'd4, 8'd3, 8'd2, 8'd1},     b: {8'd2, 8'd0, 8'd1, 8'd10},    expected: 18'd20};
    tbl[2] = '{a: {8'd55, 8'd33, 8'd22, 8'd11}, b: 32'd0,                        expected: 18'd0};
    tbl[3] = '{a: {4{8'd255}},                  b: {8'd1, 8'd1, 8'd1, 8'd1},     expected: 18'd1020};
    tbl[4] = '{a: {4{8'd255}},                  b: {4{8'd255}},                  expected: 18'd260100};
    tbl[5] = '{a: {8'd1, 8'd2, 8'd3, 8'd4},     b: {8'd5, 8'd6, 8'd7, 8'd8},     expected: 18'd70};

    b2b[0] = '{a: {8'd1, 8'd2, 8'd3, 8'd4},     b: {8'd1, 8'd1, 8'd1, 8'd1},     expected: 18'd10};
    b2b[1] = '{a: {8'd10, 8'd20, 8'd30, 8'd40}, b: {8'd2, 8'd2, 8'd2, 8'd2},     expected: 18'd200};
    b2b[2] = '{a: {8'd0, 8'd0, 8'd0, 8'd9},     b: {8'd0, 8'd0, 8'd0, 8'd9},     expected: 18'd81};

    // Reset state while rst is held, then ready right after release.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_ready",  32'(input_ready),  32'd0);
    checkOutput("reset_valid",  32'(output_valid), 32'd0);
    checkOutput("reset_result", 32'(result),       32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("release_ready", 32'(input_ready), 32'd1);

    // Table-driven single vectors.
    for (int i = 0; i < 6; i++) begin
      applyStimulus($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].expected);
    end

    // Back-to-back with input_valid held high and data changing while busy.
    @(negedge clk);
    A_vec       = b2b[0].a;
    B_vec       = b2b[0].b;
    input_valid = 1'b1;
    checkOutput("b2b_ready_first", 32'(input_ready), 32'd1);
    @(posedge clk);
    #1;
    for (int v = 0; v < 3; v++) begin
      A_vec = VW'($urandom);
      B_vec = VW'($urandom);
      if (v == 2) input_valid = 1'b0;
      busyOk = 1'b1;
      for (int c = 1; c <= N; c++) begin
        @(posedge clk);
        #1;
        if (c < N && (input_ready || output_valid)) busyOk = 1'b0;
      end
      checkOutput($sformatf("b2b%0d_busy", v),   32'(busyOk),       32'd1);
      checkOutput($sformatf("b2b%0d_valid", v),  32'(output_valid), 32'd1);
      checkOutput($sformatf("b2b%0d_result", v), 32'(result),       32'(b2b[v].expected));
      checkOutput($sformatf("b2b%0d_ready", v),  32'(input_ready),  32'd1);
      if (v < 2) begin
        A_vec = b2b[v+1].a;
        B_vec = b2b[v+1].b;
        @(posedge clk);
        #1;
        checkOutput($sformatf("b2b%0d_no_double_pulse", v), 32'(output_valid), 32'd0);
        checkOutput($sformatf("b2b%0d_accepted", v),        32'(input_ready),  32'd0);
      end
    end
    @(posedge clk);
    #1;
    checkOutput("b2b_tail_valid", 32'(output_valid), 32'd0);
    checkOutput("b2b_tail_ready", 32'(input_ready),  32'd1);

    // Reset two cycles after an accept aborts the computation.
    @(negedge clk);
    A_vec       = {4{8'd255}};
    B_vec       = {4{8'd255}};
    input_valid = 1'b1;
    @(posedge clk);
    #1;
    input_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("abort%0d_valid", c),  32'(output_valid), 32'd0);
      checkOutput($sformatf("abort%0d_result", c), 32'(result),       32'd0);
      checkOutput($sformatf("abort%0d_ready", c),  32'(input_ready),  32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("abort_release_ready", 32'(input_ready), 32'd1);
    busyOk = 1'b1;
    for (int c = 0; c < N + 2; c++) begin
      @(posedge clk);
      #1;
      if (output_valid) busyOk = 1'b0;
    end
    checkOutput("abort_no_pulse", 32'(busyOk), 32'd1);
    applyStimulus("after_abort", tbl[1].a, tbl[1].b, tbl[1].expected);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/dot_product.md
# dot_product

Sequential multiply-accumulate engine that computes the dot product of two packed N-element unsigned vectors. It uses one multiplier and processes one element pair per clock. Inputs arrive through a valid/ready handshake; the result leaves with a one-cycle valid pulse. It sits between a vector source (buffer or DMA front-end) and any consumer of scalar results, and it applies backpressure while a computation is in flight.

## Interface
- WIDTH, 8: bit width of each vector element.
- N, 4: number of elements per vector. N ≥ 1.
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  reset, synchronous and active-high.
- input_valid  input  1  source presents a vector pair.
- input_ready  output  1  engine can accept a vector pair this cycle.
- A_vec  input  WIDTH*N  packed vector A; element i = A_vec[i*WIDTH +: WIDTH].
- B_vec  input  WIDTH*N  packed vector B, packed the same way as A_vec.
- result  output  2*WIDTH+$clog2(N)  dot product Σ A[i]*B[i].
- output_valid  output  1  one-cycle pulse marking a new result.

## Operation
- States:
  - IDLE: input_ready = 1.
  - BUSY: input_ready = 0.
- Accept happens on a rising edge where input_valid && input_ready.
  - The engine captures A_vec and B_vec into internal registers.
  - It clears the accumulator and element index, then enters BUSY.
- BUSY, one element per cycle for i = 0..N-1: acc += A[i]*B[i].
  - Each product is full 2*WIDTH bits, unsigned.
  - The accumulator is 2*WIDTH+$clog2(N) bits and cannot overflow. For N=1 it is 2*WIDTH bits.
- After element N-1:
  - result ← final sum, output_valid = 1 for exactly one cycle.
  - The engine returns to IDLE.
- result holds its value until the next completion.
- A_vec and B_vec are ignored outside the accept edge. The source may change them freely while BUSY.
- input_valid while BUSY is not an error. The request stays pending and is accepted on the first edge where input_ready = 1.
- Reset values: input_ready = 0 while rst is asserted and 1 from the first cycle after release; output_valid = 0; result = 0; state = IDLE.
- rst asserted mid-computation aborts it. No output_valid pulse is produced for the aborted vector.

## Timing
- Accept at edge E0.
- Accumulation runs on edges E1..EN.
- result and output_valid are registered: both appear after edge EN and are valid for the cycle EN→EN+1.
- Latency from accept to output_valid is N cycles.
- input_ready rises in the same cycle as output_valid. A new vector can be accepted at edge EN+1, giving a throughput of one vector per N+1 cycles.
- input_ready is a registered state decode with no combinational path from input_valid.
- output_valid never asserts for two consecutive cycles.

## Configuration
- DOT_PRODUCT_SIGNED_EN defined:
  - Elements are two's-complement signed.
  - Products and accumulation are signed.
  - result is a signed value of the same width.
- DOT_PRODUCT_SIGNED_EN undefined (default): all arithmetic is unsigned.

## Structure
- Package dot_product_pkg holds:
  - the state enum (IDLE, BUSY);
  - a function returning the result width, 2*WIDTH+$clog2(N);
  - a function returning the index-counter width, max(1,$clog2(N)).
- One sub-module, dot_product_mac:
  - registered multiply-accumulate with clear and enable inputs;
  - operand width WIDTH, accumulator width from the package;
  - honours DOT_PRODUCT_SIGNED_EN.
- Top level holds the handshake FSM, the operand registers, the element index counter and the element mux.

## Test plan
- Unit vectors: A={1,1,1,1}, B={1,1,1,1} → result=4 with a single output_valid pulse, N cycles after accept.
- Ordering: A_vec={4,3,2,1}, B_vec={2,0,1,10} (MSB-first packing) → result=20.
- Zero: A={55,33,22,11}, B=0 → result=0.
- Maximum operands: A={255,255,255,255}, B={1,1,1,1} → result=1020. Also A=B={255,255,255,255} → 260100 with no truncation.
- Backpressure and back-to-back:
  - Hold input_valid high continuously with changing data.
  - Exactly one accept per N+1 cycles; input_ready is low while BUSY.
  - Each result matches the vector that was present at its accept edge.
- Reset mid-operation:
  - Assert rst two cycles after an accept.
  - No output_valid pulse, result=0, input_ready=0 during reset and 1 the cycle after release.
  - The next vector then computes correctly.
